// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle RV32I sequencer (FETCH/DECODE/EXEC/MEM/WB)
// with wait-state tolerant memory handshakes, a memory timeout trap, and a
// retired-instruction counter. Define NPU_CUSTOM_EN to make the custom-0 opcode
// launch the NPU and wait for its completion.
module multicycle_control_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned NPU_WAIT_MAX   = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_is_fetch,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [3:0]       alu_op,
  output logic [1:0]       imm_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [1:0]       reg_we,
  output logic [1:0]       wb_sel,
  output logic             npu_start,
  input  logic             npu_done,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_NPU_WAIT, S_TRAP
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [TIMEOUT_W-1:0] TO_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

  state_e               state_q, state_d;
  logic [31:0]          ir_q, ir_d;
  logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]     instret_q, instret_d;
  logic                 trap_q, trap_d;
  logic [1:0]           cause_q, cause_d;

  // Instruction class decode from the latched instruction
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_npu;
  logic is_jump, legal;
  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign alt       = ir_q[30];
  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_jump   = is_jal | is_jalr;
`ifdef NPU_CUSTOM_EN
  localparam logic [6:0] OP_NPU = 7'b0001011;
  localparam int unsigned NPU_W = $clog2(NPU_WAIT_MAX + 1) + 1;
  logic [NPU_W-1:0] npu_cnt_q, npu_cnt_d;
  assign is_npu = (opcode == OP_NPU);
`else
  logic unused_npu;
  assign is_npu     = 1'b0;
  assign unused_npu = npu_done ^ (NPU_WAIT_MAX == 0);
`endif
  assign legal = is_r | is_i | is_load | is_store | is_branch | is_jump | is_lui | is_npu;

  // rd/rs fields are consumed by the datapath, not by the sequencer
  logic unused_ir;
  assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  logic [3:0] dec_alu_op;
  logic [1:0] dec_imm_sel, dec_wb_sel;
  logic       dec_a_sel, dec_b_sel;

  // Static datapath fields; LUI has no U-immediate select, so it is sequenced as an ALU write
  always_comb begin
    dec_alu_op  = 4'b0000;
    dec_imm_sel = 2'b00;
    dec_wb_sel  = 2'b00;
    dec_a_sel   = 1'b0;
    dec_b_sel   = 1'b0;
    if (is_r || is_i) begin
      case (funct3)
        3'b000:  dec_alu_op = (is_r && alt) ? 4'b0001 : 4'b0000;
        3'b001:  dec_alu_op = 4'b0010;
        3'b010:  dec_alu_op = 4'b0011;
        3'b011:  dec_alu_op = 4'b0100;
        3'b100:  dec_alu_op = 4'b0101;
        3'b101:  dec_alu_op = alt ? 4'b0111 : 4'b0110;
        3'b110:  dec_alu_op = 4'b1000;
        default: dec_alu_op = 4'b1001;
      endcase
      dec_b_sel = is_i;
    end
    if (is_load || is_jalr || is_lui) dec_b_sel = 1'b1;
    if (is_store) begin dec_imm_sel = 2'b01; dec_b_sel = 1'b1; end
    if (is_branch) begin dec_imm_sel = 2'b10; dec_a_sel = 1'b1; dec_b_sel = 1'b1; end
    if (is_jal) begin dec_imm_sel = 2'b11; dec_a_sel = 1'b1; dec_b_sel = 1'b1; end
    if (is_load) dec_wb_sel = 2'b01;
    if (is_jump) dec_wb_sel = 2'b10;
  end

  logic in_ctrl;
  assign in_ctrl = state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB, S_NPU_WAIT};

  // Output decode: fields held DECODE..WB, enables pulse only in their own state, all zero in reset
  always_comb begin
    mem_req = 1'b0; mem_is_fetch = 1'b0; mem_we = 1'b0; ir_we = 1'b0;
    pc_we = 1'b0; pc_sel = 1'b0; alu_op = 4'b0000; imm_sel = 2'b00;
    alu_a_sel = 1'b0; alu_b_sel = 1'b0; reg_we = 2'b00; wb_sel = 2'b00;
    npu_start = 1'b0;
    if (!rst) begin
      if (in_ctrl) begin
        alu_op = dec_alu_op; imm_sel = dec_imm_sel; wb_sel = dec_wb_sel;
        alu_a_sel = dec_a_sel; alu_b_sel = dec_b_sel; pc_sel = is_jump;
      end
      case (state_q)
        S_FETCH: begin mem_req = 1'b1; mem_is_fetch = 1'b1; ir_we = mem_ready; end
        S_EXEC: begin
          if (is_branch) begin pc_we = 1'b1; pc_sel = branch_taken; end
          if (is_jump) pc_we = 1'b1;
`ifdef NPU_CUSTOM_EN
          npu_start = is_npu;
`endif
        end
        S_MEM: begin mem_req = 1'b1; mem_we = is_store; pc_we = is_store & mem_ready; end
        S_WB: begin reg_we = is_load ? 2'b10 : 2'b01; pc_we = ~is_jump; end
        default: ;
      endcase
    end
  end

  assign instret    = rst ? '0 : instret_q;
  assign trap       = trap_q & ~rst;
  assign trap_cause = rst ? 2'b00 : cause_q;

  // Next-state: sequencing, stall timeout, retire counting and sticky trap capture
  always_comb begin
    state_d = state_q; ir_d = ir_q; to_cnt_d = to_cnt_q;
    instret_d = instret_q; trap_d = trap_q; cause_d = cause_q;
`ifdef NPU_CUSTOM_EN
    npu_cnt_d = npu_cnt_q;
`endif
    case (state_q)
      S_FETCH, S_MEM: begin
        if (mem_ready) begin
          if (state_q == S_FETCH) begin
            ir_d = instr; state_d = S_DECODE;
          end else if (is_load) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH; instret_d = instret_q + CNT_W'(1);
          end
        end else if (TIMEOUT_CYCLES != 0 && to_cnt_q + TIMEOUT_W'(1) == TO_LIMIT) begin
          state_d = S_TRAP; trap_d = 1'b1; cause_d = 2'b10;
        end else begin
          to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
        end
      end
      S_DECODE: begin
        if (legal) state_d = S_EXEC;
        else begin state_d = S_TRAP; trap_d = 1'b1; cause_d = 2'b01; end
      end
      S_EXEC: begin
        if (is_load || is_store) state_d = S_MEM;
        else if (is_branch) begin state_d = S_FETCH; instret_d = instret_q + CNT_W'(1); end
        else if (is_npu) state_d = S_NPU_WAIT;
        else state_d = S_WB;
      end
`ifdef NPU_CUSTOM_EN
      S_NPU_WAIT: begin
        if (npu_done) state_d = S_WB;
        else if (npu_cnt_q == NPU_W'(NPU_WAIT_MAX)) begin
          state_d = S_TRAP; trap_d = 1'b1; cause_d = 2'b11;
        end else npu_cnt_d = npu_cnt_q + NPU_W'(1);
      end
`endif
      S_WB: begin state_d = S_FETCH; instret_d = instret_q + CNT_W'(1); end
      S_TRAP: ;
      default: state_d = S_FETCH;
    endcase
    if (state_d != state_q) begin
      to_cnt_d = '0;
`ifdef NPU_CUSTOM_EN
      npu_cnt_d = '0;
`endif
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH; ir_q <= '0; to_cnt_q <= '0;
      instret_q <= '0; trap_q <= 1'b0; cause_q <= 2'b00;
`ifdef NPU_CUSTOM_EN
      npu_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d; ir_q <= ir_d; to_cnt_q <= to_cnt_d;
      instret_q <= instret_d; trap_q <= trap_d; cause_q <= cause_d;
`ifdef NPU_CUSTOM_EN
      npu_cnt_q <= npu_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (TIMEOUT_CYCLES=4): ALU ops, load with
// wait states, store, branch, jump, illegal-opcode trap with reset recovery, fetch timeout.
module tb_multicycle_control_unit;
  logic        clk, rst;
  logic [31:0] instr;
  logic        branch_taken, mem_ready, npu_done;
  logic        mem_req, mem_is_fetch, mem_we, ir_we, pc_we, pc_sel;
  logic [3:0]  alu_op;
  logic [1:0]  imm_sel, reg_we, wb_sel, trap_cause;
  logic        alu_a_sel, alu_b_sel, npu_start, trap;
  logic [31:0] instret;

  int checks = 0;
  int failures = 0;
  int exp_instret = 0;

  multicycle_control_unit #(
    .TIMEOUT_CYCLES(4), .TIMEOUT_W(8), .CNT_W(32), .NPU_WAIT_MAX(1023)
  ) dut (
    .clk(clk), .rst(rst), .instr(instr), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_is_fetch(mem_is_fetch),
    .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_op(alu_op), .imm_sel(imm_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .reg_we(reg_we), .wb_sel(wb_sel), .npu_start(npu_start), .npu_done(npu_done),
    .instret(instret), .trap(trap), .trap_cause(trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // R/I ALU instruction with zero wait states: FETCH, DECODE, EXEC, WB
  task automatic alu_instr(input string tag, input logic [31:0] word,
                           input logic [3:0] op, input logic bsel);
    instr = word; mem_ready = 1'b1; #1;
    chk({tag, "_fetch_ir_we"}, 32'(ir_we), 1);
    tick(); #1;
    chk({tag, "_dec_alu_op"}, 32'(alu_op), 32'(op));
    tick(); #1;
    chk({tag, "_exec_pc_we"}, 32'(pc_we), 0);
    tick(); #1;
    chk({tag, "_wb_reg_we"}, 32'(reg_we), 1);
    chk({tag, "_wb_sel"}, 32'(wb_sel), 0);
    chk({tag, "_wb_alu_op"}, 32'(alu_op), 32'(op));
    chk({tag, "_wb_b_sel"}, 32'(alu_b_sel), 32'(bsel));
    chk({tag, "_wb_pc_we"}, 32'(pc_we), 1);
    chk({tag, "_wb_pc_sel"}, 32'(pc_sel), 0);
    tick(); #1;
    exp_instret++;
    chk({tag, "_instret"}, instret, 32'(exp_instret));
    chk({tag, "_next_fetch"}, 32'(mem_is_fetch), 1);
  endtask

  initial begin
    rst = 1'b1; instr = 32'h002081B3; mem_ready = 1'b1;
    branch_taken = 1'b0; npu_done = 1'b0;
    tick(); tick(); #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_ir_we", 32'(ir_we), 0);
    chk("rst_pc_we", 32'(pc_we), 0);
    chk("rst_instret", instret, 0);
    chk("rst_trap", 32'(trap), 0);
    rst = 1'b0;

    alu_instr("add", 32'h002081B3, 4'b0000, 1'b0);
    alu_instr("sub", 32'h40208133, 4'b0001, 1'b0);
    alu_instr("srai", 32'h4030D113, 4'b0111, 1'b1);

    // LW with three data wait states
    instr = 32'h0000A103; #1;
    chk("lw_fetch_ir_we", 32'(ir_we), 1);
    tick(); tick(); #1;
    chk("lw_exec_b_sel", 32'(alu_b_sel), 1);
    chk("lw_exec_mem_req", 32'(mem_req), 0);
    tick(); mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_wait_mem_req", 32'(mem_req), 1);
      chk("lw_wait_is_fetch", 32'(mem_is_fetch), 0);
      chk("lw_wait_mem_we", 32'(mem_we), 0);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("lw_ready_mem_req", 32'(mem_req), 1);
    chk("lw_ready_trap", 32'(trap), 0);
    tick(); #1;
    chk("lw_wb_reg_we", 32'(reg_we), 2);
    chk("lw_wb_sel", 32'(wb_sel), 1);
    chk("lw_wb_pc_we", 32'(pc_we), 1);
    tick(); #1;
    exp_instret++;
    chk("lw_instret", instret, 32'(exp_instret));

    // SW: write enable only in MEM, no register write, retires from MEM
    instr = 32'h0020A023; #1;
    tick(); #1;
    chk("sw_dec_imm_sel", 32'(imm_sel), 1);
    tick(); #1;
    chk("sw_exec_mem_we", 32'(mem_we), 0);
    tick(); #1;
    chk("sw_mem_we", 32'(mem_we), 1);
    chk("sw_mem_req", 32'(mem_req), 1);
    chk("sw_mem_pc_we", 32'(pc_we), 1);
    chk("sw_mem_reg_we", 32'(reg_we), 0);
    tick(); #1;
    exp_instret++;
    chk("sw_instret", instret, 32'(exp_instret));
    chk("sw_fetch_mem_we", 32'(mem_we), 0);
    chk("sw_fetch_is_fetch", 32'(mem_is_fetch), 1);

    // BEQ: pc_sel follows branch_taken in EXEC, retires with no WB cycle
    instr = 32'h00208463; #1;
    tick(); tick();
    branch_taken = 1'b0; #1;
    chk("beq_pc_sel_not_taken", 32'(pc_sel), 0);
    branch_taken = 1'b1; #1;
    chk("beq_pc_sel_taken", 32'(pc_sel), 1);
    chk("beq_pc_we", 32'(pc_we), 1);
    chk("beq_imm_sel", 32'(imm_sel), 2);
    chk("beq_a_sel", 32'(alu_a_sel), 1);
    tick(); #1;
    branch_taken = 1'b0;
    exp_instret++;
    chk("beq_instret", instret, 32'(exp_instret));
    chk("beq_next_fetch", 32'(mem_is_fetch), 1);
    chk("beq_no_reg_we", 32'(reg_we), 0);

    // JAL: jump in EXEC, link write in WB without a second PC update
    instr = 32'h008000EF; #1;
    tick(); #1;
    chk("jal_dec_wb_sel", 32'(wb_sel), 2);
    tick(); #1;
    chk("jal_exec_pc_we", 32'(pc_we), 1);
    chk("jal_exec_pc_sel", 32'(pc_sel), 1);
    chk("jal_exec_imm_sel", 32'(imm_sel), 3);
    tick(); #1;
    chk("jal_wb_reg_we", 32'(reg_we), 1);
    chk("jal_wb_sel", 32'(wb_sel), 2);
    chk("jal_wb_pc_we", 32'(pc_we), 0);
    tick(); #1;
    exp_instret++;
    chk("jal_instret", instret, 32'(exp_instret));

    // Illegal opcode traps after DECODE; one reset cycle recovers
    instr = 32'h0000007F; #1;
    tick(); tick(); #1;
    chk("ill_trap", 32'(trap), 1);
    chk("ill_cause", 32'(trap_cause), 1);
    chk("ill_mem_req", 32'(mem_req), 0);
    chk("ill_instret", instret, 32'(exp_instret));
    tick(); #1;
    chk("ill_trap_sticky", 32'(trap), 1);
    chk("ill_sticky_pc_we", 32'(pc_we), 0);
    rst = 1'b1; #1;
    chk("ill_rst_trap", 32'(trap), 0);
    tick(); rst = 1'b0; #1;
    exp_instret = 0;
    chk("post_rst_instret", instret, 32'(exp_instret));
    chk("post_rst_trap", 32'(trap), 0);
    chk("post_rst_mem_req", 32'(mem_req), 1);
    chk("post_rst_is_fetch", 32'(mem_is_fetch), 1);

    // Fetch timeout: four stalled cycles, then trap with cause 10
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_stall_mem_req", 32'(mem_req), 1);
      chk("to_stall_trap", 32'(trap), 0);
      tick();
    end
    #1;
    chk("to_trap", 32'(trap), 1);
    chk("to_cause", 32'(trap_cause), 2);
    chk("to_mem_req", 32'(mem_req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
